// File: rtl/stream_buffer_resp_if.sv
// Producer, consumer and read-port signals of the stream buffer responder.
// The slave modport is the buffer; the master modport is the producer/actor side.
interface stream_buffer_resp_if #(
  parameter int width = 10
);
  logic             wr_en;
  logic [width-1:0] wr_data;
  logic             flush_in;
  logic             release_in;
  logic             rd_en;
  logic [width-1:0] rd_addr;
  logic [width-1:0] data_out;
  logic             data_valid;
  logic             rd_err;
  logic             wr_drop;
  logic             ready_out;
  logic [width-1:0] length_out;

  modport slave (
    input  wr_en, wr_data, flush_in, release_in, rd_en, rd_addr,
    output data_out, data_valid, rd_err, wr_drop, ready_out, length_out
  );

  modport master (
    output wr_en, wr_data, flush_in, release_in, rd_en, rd_addr,
    input  data_out, data_valid, rd_err, wr_drop, ready_out, length_out
  );
endinterface

// File: rtl/stream_buffer_resp.sv
// Block buffer: filled sequentially by a producer, then read randomly by a
// computation actor with one-cycle registered responses until released.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   FILL   | accepting writes into mem[wr_ptr]; reads answered with rd_err
//   LOADED | block closed, length_out = wr_ptr; reads served, writes dropped
module stream_buffer_resp #(
  parameter int size  = 5,
  parameter int width = 10
) (
  input  logic clk,
  input  logic rst,
  stream_buffer_resp_if.slave bus
);

  localparam int PTR_W = $clog2(size + 1);

  typedef enum logic {FILL, LOADED} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [width-1:0] mem_q [size];
  logic [width-1:0] mem_d [size];
  logic [width-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             rd_err_q, rd_err_d;
  logic             wr_drop_q, wr_drop_d;

  logic [PTR_W-1:0] wr_ptr_inc;
  logic [width-1:0] length;
  logic [width-1:0] rd_word;
  logic             addr_ok;

  assign wr_ptr_inc = wr_ptr_q + PTR_W'(1);
  assign length     = {{(width-PTR_W){1'b0}}, wr_ptr_q};
  assign addr_ok    = (bus.rd_addr < length);

  // Explicit mux keeps out-of-array addresses from ever indexing mem_q.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < size; i++) begin
      if (bus.rd_addr == width'(i)) rd_word = mem_q[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    mem_d        = mem_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    rd_err_d     = 1'b0;
    wr_drop_d    = 1'b0;

    case (state_q)
      FILL: begin
        if (bus.wr_en) begin
          for (int i = 0; i < size; i++) begin
            if (wr_ptr_q == PTR_W'(i)) mem_d[i] = bus.wr_data;
          end
          wr_ptr_d = wr_ptr_inc;
          if (wr_ptr_inc == PTR_W'(size) || bus.flush_in) state_d = LOADED;
        end else if (bus.flush_in && wr_ptr_q != '0) begin
          state_d = LOADED;
        end
        if (bus.rd_en) rd_err_d = 1'b1;
      end
      LOADED: begin
        if (bus.wr_en) wr_drop_d = 1'b1;
        if (bus.rd_en) begin
          if (addr_ok) begin
            data_out_d   = rd_word;
            data_valid_d = 1'b1;
          end else begin
            data_out_d = '0;
            rd_err_d   = 1'b1;
          end
        end
        // A read in the release cycle is still served from the old block.
        if (bus.release_in) begin
          state_d  = FILL;
          wr_ptr_d = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      mem_q        <= '{default: '0};
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      rd_err_q     <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      mem_q        <= mem_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      rd_err_q     <= rd_err_d;
      wr_drop_q    <= wr_drop_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.wr_drop    = wr_drop_q;
  assign bus.ready_out  = (state_q == LOADED);
  assign bus.length_out = length;

endmodule

// File: doc/stream_buffer_resp.md
# stream_buffer_resp

Read-responder buffer for the stream-computation actors (max, min, inner product). An upstream producer writes a block of up to `size` tokens sequentially. Once the block is loaded, the buffer presents its length and answers `rd_en`/`rd_addr` requests from a computation actor with registered data. The actor's controller then releases the block so the buffer can refill.

## Interface
- `size`, 5: buffer depth in tokens.
- `width`, 10: token, address and length width.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe from the producer.
- `wr_data`  in  width  token to store.
- `flush_in`  in  1  close a partial block (count > 0) early.
- `release_in`  in  1  consumer has finished the block; return to filling.
- `rd_en`  in  1  read request from the computation actor.
- `rd_addr`  in  width  word index of the read request.
- `data_out`  out  width  read data, registered.
- `data_valid`  out  1  `data_out` holds the answer to the previous cycle's request.
- `rd_err`  out  1  one-cycle pulse: the previous request was out of range or arrived while not LOADED.
- `wr_drop`  out  1  one-cycle pulse: the previous write was discarded.
- `ready_out`  out  1  a block is loaded and readable (LOADED state).
- `length_out`  out  width  number of valid tokens in the block; drives the actor's `length_in`.

## Operation
- **Storage.** `size` × `width` register array. Write pointer `wr_ptr` counts 0..size.
- **FILL state (reset state).**
  - `wr_en` stores `wr_data` at `mem[wr_ptr]` and increments `wr_ptr`.
  - When the write that makes `wr_ptr == size` is accepted, go to LOADED.
  - `flush_in` with `wr_ptr > 0` goes to LOADED. `flush_in` with `wr_ptr == 0` is ignored.
  - `wr_en` and `flush_in` in the same cycle: accept the write, then go to LOADED with the incremented count.
- **LOADED state.**
  - `ready_out` = 1 and `length_out` = `wr_ptr`, held constant.
  - `wr_en` is discarded and pulses `wr_drop` the next cycle. `flush_in` is ignored.
  - A read with `rd_en` and `rd_addr < length_out` sets `data_out <= mem[rd_addr]` and `data_valid <= 1`.
  - A read with `rd_addr >= length_out` sets `data_out <= 0`, `data_valid <= 0` and `rd_err <= 1`.
  - `release_in` clears `wr_ptr` and returns to FILL. Memory contents are not cleared.
- **Reads outside LOADED.** `rd_en` in FILL returns `data_valid` = 0 and `rd_err` = 1. `data_out` holds its value.
- **Widths.** Addresses are compared as unsigned `width`-bit values. `length_out` is zero-extended `wr_ptr`.
- **Cycles without a read.** `data_valid` and `rd_err` are 0 in any cycle following one with no `rd_en`.

## Timing
- **Reset.** While `rst` = 0, independent of `clk`:
  - state = FILL, `wr_ptr` = 0;
  - `data_out` = 0, `data_valid` = 0, `rd_err` = 0, `wr_drop` = 0, `ready_out` = 0, `length_out` = 0.
- **Reset mid-operation.** Any in-flight read is cancelled: no `data_valid` pulse follows deassertion. Any block is lost.
- **Read latency.** One cycle: request at edge N, data valid after edge N+1. Back-to-back requests every cycle give one answer per cycle, in order.
- **Entering LOADED.** `ready_out` rises on the edge that accepts the final write or flush. The first read may be issued in that same following cycle.
- **`release_in` with `rd_en` in the same cycle.** The read is served: data is valid the next cycle. The state is FILL from that edge on.
- **Writes after release.** A `wr_en` in the cycle after release is accepted into `mem[0]`.
- **Write into a full buffer.** Unreachable in FILL, because LOADED is entered at `wr_ptr == size`.

## Test plan
- **Full fill, then read.** After reset, write 3,7,1,9,4 on 5 consecutive cycles.
  - `ready_out` = 1 and `length_out` = 5 after the 5th edge.
  - Reading addresses 0..4 back-to-back gives `data_out` 3,7,1,9,4, each one cycle later with `data_valid` = 1.
- **Partial block.** Write 2,8, then `flush_in`.
  - `length_out` = 2.
  - Read address 2: `rd_err` = 1, `data_valid` = 0, `data_out` = 0.
- **Write and flush together.** Write 5; then write 6 with `flush_in` in the same cycle. Expect `length_out` = 2 and `mem[1]` = 6.
- **Drops and release.** While LOADED, `wr_en` with 0x3FF gives a `wr_drop` pulse and unchanged data.
  - `release_in` together with a read of address 1 gives the correct data next cycle, `ready_out` = 0, `length_out` = 0.
  - A following write lands at address 0.
- **Read in FILL.** After reset, `rd_en` at address 0 gives `rd_err` = 1 and `data_valid` = 0.
- **Reset mid-read.** Pull `rst` low between a request and its response. All outputs go to 0 immediately and no `data_valid` appears after release.
